// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and sizing helper for the counter control unit.
package counter_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    // Divider width; a one-bit floor keeps the counter legal for tiny ratios.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/counter_ctrl_unit_tick_gen.sv
// Tick divider: counts while enabled, pulses tick for one cycle after each wrap.
module tick_gen
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic zero,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(DIV);

    logic [CNT_W-1:0] div_q;
    logic             at_top;

    assign at_top = (div_q == CNT_W'(DIV - 1));

    // Divider holds whenever not enabled, so a stopped count resumes where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= enable && at_top;
            if (zero) begin
                div_q <= '0;
            end else if (enable) begin
                div_q <= at_top ? '0 : div_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear control FSM driving a tick divider for a counter datapath.
// Optional count-direction toggling is enabled by defining COUNTER_CTRL_DIR_EN.
module counter_ctrl_unit
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run_stop,
    input  logic               i_clear,
    input  logic               i_mode,
    output logic               o_tick,
    output logic               o_clear,
    output logic               o_up,
    output logic               o_run,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    state_t state;
    state_t next_state;
    logic   count_en;
    logic   count_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= next_state;
        end
    end

    // Clear wins over run/stop; CLEAR always falls back to STOP; the unused code recovers.
    always_comb begin
        next_state = ST_STOP;
        case (state)
            ST_STOP: begin
                if (i_clear) begin
                    next_state = ST_CLEAR;
                end else if (i_run_stop) begin
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_STOP;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    next_state = ST_CLEAR;
                end else if (i_run_stop) begin
                    next_state = ST_STOP;
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_CLEAR: next_state = ST_STOP;
            default:  next_state = ST_STOP;
        endcase
    end

    // o_clear is high exactly while the state register holds CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_clear <= 1'b0;
        end else begin
            o_clear <= (next_state == ST_CLEAR);
        end
    end

    // Count only in cycles that stay in RUN, so leaving RUN never leaves a stray tick behind.
    assign count_en   = (state == ST_RUN) && (next_state == ST_RUN);
    assign count_zero = (state == ST_CLEAR);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (count_en),
        .zero   (count_zero),
        .tick   (o_tick)
    );

    assign o_run   = (state == ST_RUN);
    assign o_state = state;

`ifdef COUNTER_CTRL_DIR_EN
    logic up_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q <= 1'b1;
        end else if (i_mode) begin
            up_q <= ~up_q;
        end
    end

    assign o_up = up_q;
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign o_up        = 1'b1;
`endif

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed bench for counter_ctrl_unit with DIV = 10 (CLK_HZ=100, TICK_HZ=10).
module tb_counter_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       i_run_stop;
    logic       i_clear;
    logic       i_mode;
    logic       o_tick;
    logic       o_clear;
    logic       o_up;
    logic       o_run;
    logic [1:0] o_state;

    int checks   = 0;
    int failures = 0;

    counter_ctrl_unit #(
        .CLK_HZ  (100),
        .TICK_HZ (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_run_stop (i_run_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .o_tick     (o_tick),
        .o_clear    (o_clear),
        .o_up       (o_up),
        .o_run      (o_run),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive the selected inputs for one clock edge; call and return on a falling edge.
    task automatic pulse(input bit rs, input bit clr, input bit md);
        i_run_stop = rs;
        i_clear    = clr;
        i_mode     = md;
        @(negedge clk);
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_mode     = 1'b0;
    endtask

    // Falling edges until o_tick is seen; -1 if the budget expires.
    task automatic wait_tick(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_tick) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    int exp_up;

    initial begin
        rst        = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_mode     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_state", int'(o_state), 0);
        check_eq("rst_run",   int'(o_run),   0);
        check_eq("rst_tick",  int'(o_tick),  0);
        check_eq("rst_clear", int'(o_clear), 0);
        check_eq("rst_up",    int'(o_up),    1);
        rst = 1'b0;
        @(negedge clk);

        // Start: RUN next cycle, first tick 10 cycles in, then every 10.
        pulse(1, 0, 0);
        check_eq("start_run",   int'(o_run),   1);
        check_eq("start_state", int'(o_state), 1);
        wait_tick(n);
        check_eq("first_tick", n, 10);
        wait_tick(n);
        check_eq("tick_period", n, 10);

        // Stop with divider at 4, no ticks while stopped, resume gives tick after 6.
        repeat (4) @(negedge clk);
        pulse(1, 0, 0);
        check_eq("stop_run",   int'(o_run),   0);
        check_eq("stop_state", int'(o_state), 0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_tick) n++;
        end
        check_eq("stop_no_tick", n, 0);
        pulse(1, 0, 0);
        check_eq("resume_run", int'(o_run), 1);
        wait_tick(n);
        check_eq("resume_tick", n, 6);

        // Clear and run/stop together in RUN: clear wins, one-cycle o_clear, then STOP.
        repeat (3) @(negedge clk);
        pulse(1, 1, 0);
        check_eq("clr_state",    int'(o_state), 2);
        check_eq("clr_pulse",    int'(o_clear), 1);
        check_eq("clr_tick",     int'(o_tick),  0);
        check_eq("clr_run",      int'(o_run),   0);
        @(negedge clk);
        check_eq("clr_to_stop",  int'(o_state), 0);
        check_eq("clr_one_cyc",  int'(o_clear), 0);
        pulse(1, 0, 0);
        wait_tick(n);
        check_eq("clr_div_zero", n, 10);

        // Clear from STOP; run/stop during CLEAR is ignored.
        pulse(1, 0, 0);
        check_eq("stop2_state", int'(o_state), 0);
        pulse(0, 1, 0);
        check_eq("stop_clr_state", int'(o_state), 2);
        pulse(1, 0, 0);
        check_eq("clr_ignore_rs", int'(o_state), 0);
        check_eq("clr_ignore_clear", int'(o_clear), 0);

        // Direction toggles; state untouched.
        exp_up = 1;
        for (int i = 0; i < 3; i++) begin
`ifdef COUNTER_CTRL_DIR_EN
            exp_up = 1 - exp_up;
`endif
            pulse(0, 0, 1);
            check_eq("mode_up",    int'(o_up),    exp_up);
            check_eq("mode_state", int'(o_state), 0);
        end

        // Reset mid-RUN with divider at 7.
        pulse(1, 0, 0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mrst_tick",  int'(o_tick),  0);
        check_eq("mrst_state", int'(o_state), 0);
        check_eq("mrst_run",   int'(o_run),   0);
        check_eq("mrst_up",    int'(o_up),    1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_clear) n++;
            if (o_state != 2'b00) n++;
        end
        check_eq("mrst_no_clear", n, 0);

        // Divider restarts from zero; reset drops a live tick immediately.
        pulse(1, 0, 0);
        wait_tick(n);
        check_eq("mrst_div_zero", n, 10);
        check_eq("tick_live", int'(o_tick), 1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_tick_drop", int'(o_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Held-high run/stop counts as an event every cycle.
        i_run_stop = 1'b1;
        @(negedge clk);
        check_eq("held_rs_1", int'(o_state), 1);
        @(negedge clk);
        i_run_stop = 1'b0;
        check_eq("held_rs_2", int'(o_state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
